// File: rtl/alu_share_arbiter_if.sv
// Requester, result and ALU-side signals of the shared-ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface alu_share_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int OP_W   = 5,
    parameter int ZERO_W = 8
);
    logic              req0;
    logic [WIDTH-1:0]  a0;
    logic [WIDTH-1:0]  b0;
    logic [OP_W-1:0]   op0;
    logic              req1;
    logic [WIDTH-1:0]  a1;
    logic [WIDTH-1:0]  b1;
    logic [OP_W-1:0]   op1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [WIDTH-1:0]  res_c;
    logic [ZERO_W-1:0] res_zero;
    logic              busy;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [WIDTH-1:0]  alu_c;
    logic [ZERO_W-1:0] alu_zero;

    modport slave (
        input  req0, a0, b0, op0, req1, a1, b1, op1, alu_c, alu_zero,
        output gnt0, gnt1, done0, done1, res_c, res_zero, busy, alu_a, alu_b, alu_op
    );

    modport master (
        output req0, a0, b0, op0, req1, a1, b1, op1, alu_c, alu_zero,
        input  gnt0, gnt1, done0, done1, res_c, res_zero, busy, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters: grant, drive the ALU
// with the winner's latched operands, wait ALU_LAT cycles, capture, pulse done.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int OP_W    = 5,
    parameter int ZERO_W  = 8,
    parameter int ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                rstn,
    alu_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic              rr_ptr_reg;
    logic [1:0]        gnt_reg;
    logic [1:0]        done_reg;
    logic              busy_reg;
    logic [WIDTH-1:0]  alu_a_reg;
    logic [WIDTH-1:0]  alu_b_reg;
    logic [OP_W-1:0]   alu_op_reg;
    logic [WIDTH-1:0]  res_c_reg;
    logic [ZERO_W-1:0] res_zero_reg;

    logic              any_req;
    logic              pick1;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [OP_W-1:0]   sel_op;

    // rr_ptr_reg names the requester that wins a tie; it flips to the other
    // side after every grant, so reset (0) lets req0 win the first tie.
    assign any_req = bus.req0 | bus.req1;
    assign pick1   = bus.req1 & (~bus.req0 | rr_ptr_reg);
    assign sel_a   = pick1 ? bus.a1  : bus.a0;
    assign sel_b   = pick1 ? bus.b1  : bus.b0;
    assign sel_op  = pick1 ? bus.op1 : bus.op0;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            rr_ptr_reg   <= 1'b0;
            gnt_reg      <= '0;
            done_reg     <= '0;
            busy_reg     <= 1'b0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= '0;
            res_c_reg    <= '0;
            res_zero_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        gnt_reg    <= {pick1, ~pick1};
                        rr_ptr_reg <= ~pick1;
                        alu_a_reg  <= sel_a;
                        alu_b_reg  <= sel_b;
                        alu_op_reg <= sel_op;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == LAST_CNT) begin
                        res_c_reg    <= bus.alu_c;
                        res_zero_reg <= bus.alu_zero;
                        done_reg     <= gnt_reg;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= '0;
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= '0;
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt_reg[0];
    assign bus.gnt1     = gnt_reg[1];
    assign bus.done0    = done_reg[0];
    assign bus.done1    = done_reg[1];
    assign bus.busy     = busy_reg;
    assign bus.alu_a    = alu_a_reg;
    assign bus.alu_b    = alu_b_reg;
    assign bus.alu_op   = alu_op_reg;
    assign bus.res_c    = res_c_reg;
    assign bus.res_zero = res_zero_reg;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table of single operations, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    localparam int WIDTH  = 32;
    localparam int OP_W   = 5;
    localparam int ZERO_W = 8;
    localparam int LAT1   = 1;
    localparam int LAT3   = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(WIDTH), .OP_W(OP_W), .ZERO_W(ZERO_W)) bus1 ();
    alu_share_arbiter_if #(.WIDTH(WIDTH), .OP_W(OP_W), .ZERO_W(ZERO_W)) bus3 ();

    alu_share_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W), .ZERO_W(ZERO_W), .ALU_LAT(LAT1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(bus1)
    );
    alu_share_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W), .ZERO_W(ZERO_W), .ALU_LAT(LAT3)) dut3 (
        .clk(clk), .rstn(rstn), .bus(bus3)
    );

    // Bench-side ALU: add, sub, anything else yields 0; Zero is 1 when C is 0.
    function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [OP_W-1:0] op);
        case (op)
            5'b00001: return a + b;
            5'b00010: return a - b;
            default:  return '0;
        endcase
    endfunction

    assign bus1.alu_c    = alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_op);
    assign bus1.alu_zero = (bus1.alu_c == '0) ? 8'h01 : 8'h00;
    assign bus3.alu_c    = alu_f(bus3.alu_a, bus3.alu_b, bus3.alu_op);
    assign bus3.alu_zero = (bus3.alu_c == '0) ? 8'h01 : 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic              req0;
        logic              req1;
        logic [WIDTH-1:0]  a0;
        logic [WIDTH-1:0]  b0;
        logic [OP_W-1:0]   op0;
        logic [WIDTH-1:0]  a1;
        logic [WIDTH-1:0]  b1;
        logic [OP_W-1:0]   op1;
        logic [1:0]        exp_gnt;
        logic [WIDTH-1:0]  exp_c;
        logic [ZERO_W-1:0] exp_zero;
    } vec_t;

    vec_t rows[6];

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
    endtask

    // One complete operation on the ALU_LAT=1 instance, starting and ending idle.
    task automatic run_row(input string tag, input vec_t v);
        int waited;
        bus1.req0 = v.req0; bus1.a0 = v.a0; bus1.b0 = v.b0; bus1.op0 = v.op0;
        bus1.req1 = v.req1; bus1.a1 = v.a1; bus1.b1 = v.b1; bus1.op1 = v.op1;
        @(negedge clk);
        check({tag, "_gnt"}, 64'({bus1.gnt1, bus1.gnt0, bus1.busy, bus1.done1, bus1.done0}),
              64'({v.exp_gnt, 1'b1, 2'b00}));
        waited = 0;
        while (!(bus1.done0 || bus1.done1) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_lat"}, 64'(waited), 64'(LAT1));
        check({tag, "_done"}, 64'({bus1.done1, bus1.done0, bus1.gnt1, bus1.gnt0}),
              64'({v.exp_gnt, v.exp_gnt}));
        check({tag, "_res"}, 64'({bus1.res_zero, bus1.res_c}), 64'({v.exp_zero, v.exp_c}));
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 64'({bus1.gnt1, bus1.gnt0, bus1.done1, bus1.done0, bus1.busy}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int dn0, dn1, waited;
        logic [1:0] prev;
        vec_t v;

        rows[0] = '{1'b1, 1'b0, 32'd5, 32'd3, 5'b00001, 32'd0, 32'd0, 5'd0,
                    2'b01, 32'd8, 8'h00};
        rows[1] = '{1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'd7, 32'd7, 5'b00010,
                    2'b10, 32'd0, 8'h01};
        rows[2] = '{1'b1, 1'b1, 32'd100, 32'd1, 5'b00010, 32'd1, 32'd2, 5'b00001,
                    2'b01, 32'd99, 8'h00};
        rows[3] = '{1'b1, 1'b1, 32'd3, 32'd3, 5'b00001, 32'hFFFF_FFFF, 32'd1, 5'b00001,
                    2'b10, 32'd0, 8'h01};
        rows[4] = '{1'b1, 1'b1, 32'd0, 32'd1, 5'b00010, 32'd4, 32'd4, 5'b00001,
                    2'b01, 32'hFFFF_FFFF, 8'h00};
        rows[5] = '{1'b0, 1'b1, 32'd9, 32'd9, 5'b00001, 32'h8000_0000, 32'h8000_0000, 5'b00001,
                    2'b10, 32'd0, 8'h01};

        rstn = 1'b1;
        bus1.req0 = 0; bus1.a0 = 0; bus1.b0 = 0; bus1.op0 = 0;
        bus1.req1 = 0; bus1.a1 = 0; bus1.b1 = 0; bus1.op1 = 0;
        bus3.req0 = 0; bus3.a0 = 0; bus3.b0 = 0; bus3.op0 = 0;
        bus3.req1 = 0; bus3.a1 = 0; bus3.b1 = 0; bus3.op1 = 0;
        repeat (3) @(negedge clk);
        check("reset_ctl", 64'({bus1.gnt1, bus1.gnt0, bus1.done1, bus1.done0, bus1.busy}), 64'(0));
        check("reset_res", 64'({bus1.res_zero, bus1.res_c}), 64'(0));
        check("reset_alu", 64'({bus1.alu_op, bus1.alu_a}), 64'(0));
        check("reset_alu_b", 64'(bus1.alu_b), 64'(0));
        rstn = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_row($sformatf("row%0d", i), rows[i]);
            $display("[TB] row %0d applied, res_c=%0h res_zero=%0h", i, bus1.res_c, bus1.res_zero);
        end

        // Both requesters held from reset: grants must alternate 0,1,0,1.
        pulse_reset();
        bus1.a0 = 32'd1; bus1.b0 = 32'd1; bus1.op0 = 5'b00001;
        bus1.a1 = 32'd5; bus1.b1 = 32'd2; bus1.op1 = 5'b00010;
        bus1.req0 = 1'b1; bus1.req1 = 1'b1;
        prev = 2'b00; dn0 = 0; dn1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if ({bus1.gnt1, bus1.gnt0} != prev && {bus1.gnt1, bus1.gnt0} != 2'b00)
                order.push_back(bus1.gnt1 ? 1 : 0);
            if (bus1.done0) dn0++;
            if (bus1.done1) dn1++;
            prev = {bus1.gnt1, bus1.gnt0};
        end
        bus1.req0 = 1'b0; bus1.req1 = 1'b0;
        check("tie_ngrants", 64'(order.size()), 64'(4));
        for (int i = 0; i < order.size(); i++)
            check($sformatf("tie_order%0d", i), 64'(order[i]), 64'(i % 2));
        check("tie_dones", 64'({dn0, dn1}), 64'({32'd2, 32'd2}));
        $display("[TB] tie sequence: %0d grants, done0=%0d done1=%0d", order.size(), dn0, dn1);
        @(negedge clk);

        // req0 held alone: re-granted every 3 cycles, mid-EXEC operand change ignored.
        bus1.a0 = 32'd10; bus1.b0 = 32'd4; bus1.op0 = 5'b00001; bus1.req0 = 1'b1;
        @(negedge clk);
        check("hold_gnt", 64'({bus1.gnt1, bus1.gnt0}), 64'(2'b01));
        bus1.a0 = 32'd100;
        @(negedge clk);
        check("hold_done", 64'({bus1.done1, bus1.done0}), 64'(2'b01));
        check("hold_res", 64'(bus1.res_c), 64'(32'd14));
        @(negedge clk);
        check("hold_gap", 64'({bus1.gnt0, bus1.busy}), 64'(0));
        @(negedge clk);
        check("hold_regrant", 64'({bus1.gnt1, bus1.gnt0}), 64'(2'b01));
        @(negedge clk);
        check("hold_res2", 64'({bus1.done0, bus1.res_c}), 64'({1'b1, 32'd104}));
        bus1.req0 = 1'b0;
        @(negedge clk);
        $display("[TB] hold sequence done, res_c=%0h", bus1.res_c);

        // Asynchronous reset in the middle of EXEC.
        bus1.a0 = 32'd21; bus1.b0 = 32'd21; bus1.op0 = 5'b00001; bus1.req0 = 1'b1;
        @(negedge clk);
        #2;
        rstn = 1'b1;
        bus1.req0 = 1'b0;
        #1;
        check("arst_ctl", 64'({bus1.gnt1, bus1.gnt0, bus1.done1, bus1.done0, bus1.busy}), 64'(0));
        check("arst_alu", 64'({bus1.alu_op, bus1.alu_a}), 64'(0));
        #1;
        rstn = 1'b0;
        dn0 = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus1.done0 || bus1.done1) dn0++;
        end
        check("arst_nodone", 64'(dn0), 64'(0));
        v = '{1'b1, 1'b0, 32'd6, 32'd2, 5'b00010, 32'd0, 32'd0, 5'd0, 2'b01, 32'd4, 8'h00};
        run_row("arst_after", v);
        $display("[TB] async reset sequence done");

        // ALU_LAT=3 instance.
        bus3.a0 = 32'd20; bus3.b0 = 32'd22; bus3.op0 = 5'b00001; bus3.req0 = 1'b1;
        @(negedge clk);
        check("lat3_gnt", 64'({bus3.gnt1, bus3.gnt0, bus3.busy}), 64'(3'b011));
        check("lat3_hold", 64'(bus3.res_c), 64'(0));
        waited = 0;
        while (!bus3.done0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("lat3_lat", 64'(waited), 64'(LAT3));
        check("lat3_res", 64'({bus3.res_zero, bus3.res_c}), 64'({8'h00, 32'd42}));
        bus3.req0 = 1'b0;
        @(negedge clk);
        check("lat3_idle", 64'({bus3.gnt0, bus3.done0, bus3.busy}), 64'(0));
        $display("[TB] lat3 op: latency %0d res_c=%0h", waited, bus3.res_c);

        // Random traffic against a transaction-level model of the ALU_LAT=1 instance.
        pulse_reset();
        begin
            int          owner;
            int          age;
            bit          fav1;
            logic [31:0] m_res, pend_c;
            logic [7:0]  m_zero, pend_z;
            bit          r_req[2];
            logic [31:0] r_a[2], r_b[2];
            logic [4:0]  r_op[2];
            logic [1:0]  exp_g, exp_d;
            owner = -1; age = 0; fav1 = 1'b0;
            m_res = '0; m_zero = '0; pend_c = '0; pend_z = '0;
            for (int i = 0; i < 2; i++) begin
                r_req[i] = 1'b0; r_a[i] = '0; r_b[i] = '0; r_op[i] = '0;
            end
            for (int cyc = 0; cyc < 300; cyc++) begin
                @(negedge clk);
                exp_g = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
                exp_d = (owner >= 0 && age == LAT1) ? exp_g : 2'b00;
                check($sformatf("rand_ctl@%0d", cyc),
                      64'({bus1.gnt1, bus1.gnt0, bus1.done1, bus1.done0, bus1.busy}),
                      64'({exp_g, exp_d, owner >= 0}));
                check($sformatf("rand_res@%0d", cyc), 64'({bus1.res_zero, bus1.res_c}),
                      64'({m_zero, m_res}));
                if (exp_d != 2'b00)
                    $display("[TB] rand op done by req%0d res_c=%0h res_zero=%0h",
                             owner, bus1.res_c, bus1.res_zero);

                for (int i = 0; i < 2; i++) begin
                    if (!r_req[i]) begin
                        if ($urandom_range(2) == 0) begin
                            r_req[i] = 1'b1;
                            r_a[i]   = $urandom;
                            r_b[i]   = ($urandom_range(3) == 0) ? r_a[i] : $urandom;
                            r_op[i]  = ($urandom_range(3) == 0) ? 5'($urandom) :
                                       ($urandom_range(1) == 0) ? 5'b00001 : 5'b00010;
                        end
                    end else if (exp_d[i]) begin
                        if ($urandom_range(1) == 0) r_req[i] = 1'b0;
                    end else if ($urandom_range(15) == 0) begin
                        r_req[i] = 1'b0;
                    end else if ($urandom_range(3) == 0) begin
                        r_a[i] = $urandom;
                        r_b[i] = $urandom;
                    end
                end
                bus1.req0 = r_req[0]; bus1.a0 = r_a[0]; bus1.b0 = r_b[0]; bus1.op0 = r_op[0];
                bus1.req1 = r_req[1]; bus1.a1 = r_a[1]; bus1.b1 = r_b[1]; bus1.op1 = r_op[1];

                // An operation lasts LAT1+2 cycles; only an idle arbiter looks at requests.
                if (owner >= 0) begin
                    age++;
                    if (age == LAT1) begin
                        m_res  = pend_c;
                        m_zero = pend_z;
                    end
                    if (age > LAT1) owner = -1;
                end else if (r_req[0] || r_req[1]) begin
                    if (r_req[0] && r_req[1]) owner = fav1 ? 1 : 0;
                    else                      owner = r_req[1] ? 1 : 0;
                    fav1   = (owner == 0);
                    age    = 0;
                    pend_c = alu_f(r_a[owner], r_b[owner], r_op[owner]);
                    pend_z = (pend_c == '0) ? 8'h01 : 8'h00;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
